video_pattern_gen: RTL

Parametrised video timing and test-pattern generator for the HDMI output path. Produces hsync/vsync/de and per-pixel RGB for any resolution set by parameters, with four run-time selectable patterns (colour bar, grid, gradient, solid). Sits on the pixel clock directly ahead of the TMDS encoder, as the successor to the fixed-resolution colour-bar source.

---
 rtl/video_pattern_gen.sv | 125 ++++++++++++
 1 files changed

// File: rtl/video_pattern_gen.sv
// Parametrised video timing and test-pattern generator (hsync/vsync/de + RGB).
// All outputs are registered one cycle behind the h/v counters.
module video_pattern_gen #(
  parameter int H_ACTIVE  = 1280,
  parameter int H_FP      = 110,
  parameter int H_SYNC    = 40,
  parameter int H_BP      = 220,
  parameter int V_ACTIVE  = 720,
  parameter int V_FP      = 5,
  parameter int V_SYNC    = 5,
  parameter int V_BP      = 20,
  parameter int HS_POL    = 1,
  parameter int VS_POL    = 1,
  parameter int COLOR_W   = 8,
  parameter int GRID_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [3*COLOR_W-1:0] rgb,
  output logic [11:0]          pix_x,
  output logic [11:0]          pix_y,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BPW     = $clog2(BAR_W + 1);
  localparam int CW3     = 3 * COLOR_W;
  localparam int GMASK   = (1 << GRID_LOG2) - 1;
  // {R,G,B} on/off flags per bar, index 0 in the low bits
  localparam logic [23:0] BAR_LUT = 24'b000_001_100_101_010_011_110_111;

  logic [HW-1:0]  h_cnt;
  logic [VW-1:0]  v_cnt;
  logic [1:0]     mode_q;
  logic [CW3-1:0] solid_q;
  logic [BPW-1:0] bar_pos;
  logic [2:0]     bar_idx;

  logic           h_last, v_last, frame_org, active, h_win, v_win, grid_on;
  logic [1:0]     mode_eff;
  logic [CW3-1:0] solid_eff, pix_rgb;
  logic [2:0]     bar_flags;
  logic [COLOR_W-1:0] gray;

  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
  assign frame_org = (h_cnt == '0) && (v_cnt == '0);
  assign active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign h_win     = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign v_win     = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

  // Pixel (0,0) must already use the mode being captured on that same cycle.
  assign mode_eff  = frame_org ? mode : mode_q;
  assign solid_eff = frame_org ? solid_rgb : solid_q;

  assign bar_flags = BAR_LUT[int'(bar_idx) * 3 +: 3];
  assign gray      = COLOR_W'(h_cnt);
  assign grid_on   = ((h_cnt & HW'(GMASK)) == '0) || ((v_cnt & VW'(GMASK)) == '0) ||
                     (h_cnt == HW'(H_ACTIVE - 1)) || (v_cnt == VW'(V_ACTIVE - 1));

  always_comb begin
    pix_rgb = '0;
    case (mode_eff)
      2'd0:    pix_rgb = {{COLOR_W{bar_flags[2]}}, {COLOR_W{bar_flags[1]}}, {COLOR_W{bar_flags[0]}}};
      2'd1:    pix_rgb = grid_on ? '1 : '0;
      2'd2:    pix_rgb = {gray, gray, gray};
      default: pix_rgb = solid_eff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      mode_q      <= '0;
      solid_q     <= '0;
      bar_pos     <= '0;
      bar_idx     <= '0;
      hsync       <= ~1'(HS_POL);
      vsync       <= ~1'(VS_POL);
      de          <= 1'b0;
      rgb         <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;

      // Bar index tracked incrementally; saturates at 7 for remainder columns.
      if (h_last) begin
        bar_pos <= '0;
        bar_idx <= '0;
      end else if (bar_pos == BPW'(BAR_W - 1)) begin
        bar_pos <= '0;
        bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end else begin
        bar_pos <= bar_pos + 1'b1;
      end

      if (frame_org) begin
        mode_q  <= mode;
        solid_q <= solid_rgb;
      end

      hsync       <= h_win ? 1'(HS_POL) : ~1'(HS_POL);
      vsync       <= v_win ? 1'(VS_POL) : ~1'(VS_POL);
      de          <= active;
      rgb         <= active ? pix_rgb : '0;
      pix_x       <= active ? 12'(h_cnt) : 12'd0;
      pix_y       <= active ? 12'(v_cnt) : 12'd0;
      frame_start <= frame_org;
    end
  end

endmodule
